mbisr_repairable_mem: RTL and testbench

//  Single-port synchronous SRAM model with spare-row redundancy and cell fault injection.
//  It is the repair target for the MBIST/MBISR controllers: BIST finds failing addresses,
//  and MBISR loads them into the repair map so later accesses redirect to spare rows.
//  It adds self-clear after reset, a configurable read pipeline and bounds checking.

---
 rtl/mbisr_repairable_mem.sv | 236 +++++++++++++++++++++++
 tb/tb_mbisr_repairable_mem.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbisr_repairable_mem.sv
// Single-port SRAM model with spare-row repair, stuck-at fault injection,
// self-clear after reset and a 1- or 2-cycle read pipeline.
module mbisr_repairable_mem #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int MEM_SIZE     = 256,
   parameter int SPARE_ROWS   = 4,
   parameter int NUM_FAULTS   = 2,
   parameter int READ_LATENCY = 1,
   localparam int CW = $clog2(SPARE_ROWS + 1),
   localparam int IW = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_en,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_rvalid,
   output logic                  oor_err,
   output logic                  busy,
   input  logic                  rep_we,
   input  logic [ADDR_WIDTH-1:0] rep_addr,
   output logic [CW-1:0]         rep_count,
   output logic                  rep_overflow,
   input  logic                  flt_we,
   input  logic [IW-1:0]         flt_idx,
   input  logic                  flt_en,
   input  logic [ADDR_WIDTH-1:0] flt_addr,
   input  logic [BW-1:0]         flt_bit,
   input  logic                  flt_val
);

   localparam int TOTAL = MEM_SIZE + SPARE_ROWS;
   localparam int RW    = $clog2(TOTAL);
   localparam logic [ADDR_WIDTH:0] MS_W = (ADDR_WIDTH + 1)'(MEM_SIZE);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] clr_cnt_q, clr_cnt_d;

   // Rows 0..MEM_SIZE-1 are the main array; spare k lives at row MEM_SIZE+k.
   logic [DATA_WIDTH-1:0] mem_q [TOTAL];

   logic [SPARE_ROWS-1:0][ADDR_WIDTH-1:0] rep_addr_q, rep_addr_d;
   logic [CW-1:0]                         rep_count_q, rep_count_d;
   logic                                  rep_ovf_q, rep_ovf_d;
   logic                                  rep_known;

   logic [NUM_FAULTS-1:0]                 flt_en_q, flt_en_d;
   logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] flt_addr_q, flt_addr_d;
   logic [NUM_FAULTS-1:0][BW-1:0]         flt_bit_q, flt_bit_d;
   logic [NUM_FAULTS-1:0]                 flt_val_q, flt_val_d;

   logic                  acc, in_range, hit;
   logic [RW-1:0]         acc_row;
   logic                  wr_en;
   logic [RW-1:0]         wr_row;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_vld_d;
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic                  src_vld;
   logic [DATA_WIDTH-1:0] src_data;

   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  oor_q, oor_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         if (clr_cnt_q == RW'(TOTAL - 1)) begin
            state_d   = ST_READY;
            clr_cnt_d = '0;
         end else begin
            clr_cnt_d = clr_cnt_q + RW'(1);
         end
      end
   end

   always_comb begin
      busy = (state_q == ST_CLEAR);
   end

   // Access decode: lookup uses the map as it stood before this edge.
   always_comb begin
      acc      = mem_en && !busy;
      in_range = {1'b0, mem_addr} < MS_W;
      hit      = 1'b0;
      acc_row  = RW'(mem_addr);
      for (int i = 0; i < SPARE_ROWS; i++) begin
         if (CW'(i) < rep_count_q && rep_addr_q[i] == mem_addr) begin
            hit     = 1'b1;
            acc_row = RW'(MEM_SIZE + i);
         end
      end

      rd_vld_d  = acc && !mem_we;
      rd_data_d = '0;
      if (in_range) begin
         rd_data_d = mem_q[acc_row];
         // Walk high to low so the lowest slot's forcing lands last.
         if (!hit) begin
            for (int j = NUM_FAULTS - 1; j >= 0; j--) begin
               if (flt_en_q[j] && flt_addr_q[j] == mem_addr)
                  rd_data_d[flt_bit_q[j]] = flt_val_q[j];
            end
         end
      end

      if (busy) begin
         wr_en   = 1'b1;
         wr_row  = clr_cnt_q;
         wr_data = '0;
      end else begin
         wr_en   = acc && mem_we && in_range;
         wr_row  = acc_row;
         wr_data = mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_row] <= wr_data;
   end

   always_comb begin
      rep_addr_d  = rep_addr_q;
      rep_count_d = rep_count_q;
      rep_ovf_d   = rep_ovf_q;
      rep_known   = 1'b0;
      for (int i = 0; i < SPARE_ROWS; i++) begin
         if (CW'(i) < rep_count_q && rep_addr_q[i] == rep_addr) rep_known = 1'b1;
      end
      if (rep_we && ({1'b0, rep_addr} < MS_W) && !rep_known) begin
         if (rep_count_q == CW'(SPARE_ROWS)) begin
            rep_ovf_d = 1'b1;
         end else begin
            for (int i = 0; i < SPARE_ROWS; i++) begin
               if (CW'(i) == rep_count_q) rep_addr_d[i] = rep_addr;
            end
            rep_count_d = rep_count_q + CW'(1);
         end
      end
   end

   always_comb begin
      flt_en_d   = flt_en_q;
      flt_addr_d = flt_addr_q;
      flt_bit_d  = flt_bit_q;
      flt_val_d  = flt_val_q;
      if (flt_we) begin
         for (int j = 0; j < NUM_FAULTS; j++) begin
            if (IW'(j) == flt_idx) begin
               flt_en_d[j]   = flt_en;
               flt_addr_d[j] = flt_addr;
               flt_bit_d[j]  = flt_bit;
               flt_val_d[j]  = flt_val;
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  pipe_vld_q;
         logic [DATA_WIDTH-1:0] pipe_data_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               pipe_vld_q  <= 1'b0;
               pipe_data_q <= '0;
            end else begin
               pipe_vld_q  <= rd_vld_d;
               pipe_data_q <= rd_data_d;
            end
         end
         assign src_vld  = pipe_vld_q;
         assign src_data = pipe_data_q;
      end else begin : g_lat1
         assign src_vld  = rd_vld_d;
         assign src_data = rd_data_d;
      end
   endgenerate

   always_comb begin
      rvalid_d = src_vld;
      rdata_d  = src_vld ? src_data : rdata_q;
      oor_d    = acc && !in_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         oor_q       <= 1'b0;
         rep_addr_q  <= '0;
         rep_count_q <= '0;
         rep_ovf_q   <= 1'b0;
         flt_en_q    <= '0;
         flt_addr_q  <= '0;
         flt_bit_q   <= '0;
         flt_val_q   <= '0;
      end else begin
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         oor_q       <= oor_d;
         rep_addr_q  <= rep_addr_d;
         rep_count_q <= rep_count_d;
         rep_ovf_q   <= rep_ovf_d;
         flt_en_q    <= flt_en_d;
         flt_addr_q  <= flt_addr_d;
         flt_bit_q   <= flt_bit_d;
         flt_val_q   <= flt_val_d;
      end
   end

   assign mem_rdata    = rdata_q;
   assign mem_rvalid   = rvalid_q;
   assign oor_err      = oor_q;
   assign rep_count    = rep_count_q;
   assign rep_overflow = rep_ovf_q;

endmodule

// File: tb/tb_mbisr_repairable_mem.sv
// Two instances (defaults, and MEM_SIZE=200 / READ_LATENCY=2) share one
// stimulus stream; a queue-based model predicts every output each cycle.
module tb_mbisr_repairable_mem;

   localparam int SP = 4;
   localparam int NF = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_en, mem_we, rep_we, flt_we, flt_en, flt_val;
   logic [7:0] mem_addr, mem_wdata, rep_addr, flt_addr;
   logic [0:0] flt_idx;
   logic [2:0] flt_bit;

   logic [7:0] o_rd   [2];
   logic       o_rv   [2];
   logic       o_oor  [2];
   logic       o_busy [2];
   logic [2:0] o_rcnt [2];
   logic       o_ovf  [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mbisr_repairable_mem dut_a (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(o_rd[0]), .mem_rvalid(o_rv[0]), .oor_err(o_oor[0]),
      .busy(o_busy[0]), .rep_we(rep_we), .rep_addr(rep_addr), .rep_count(o_rcnt[0]),
      .rep_overflow(o_ovf[0]), .flt_we(flt_we), .flt_idx(flt_idx), .flt_en(flt_en),
      .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_val(flt_val));

   mbisr_repairable_mem #(.MEM_SIZE(200), .READ_LATENCY(2)) dut_b (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(o_rd[1]), .mem_rvalid(o_rv[1]), .oor_err(o_oor[1]),
      .busy(o_busy[1]), .rep_we(rep_we), .rep_addr(rep_addr), .rep_count(o_rcnt[1]),
      .rep_overflow(o_ovf[1]), .flt_we(flt_we), .flt_idx(flt_idx), .flt_en(flt_en),
      .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_val(flt_val));

   function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct {int due; logic [7:0] d;} rd_t;

   int         ms [2] = '{256, 200};
   int         rl [2] = '{1, 2};
   logic [7:0] mm [2][256];
   logic [7:0] sp [2][SP];
   int         rmap [2][SP];
   int         rn [2];
   bit         ovf [2];
   int         left [2];
   rd_t        rq [2][$];
   bit         e_rv [2];
   logic [7:0] e_rd [2];
   bit         e_oor [2];
   bit         fen [NF];
   int         faddr [NF];
   int         fbit [NF];
   bit         fval [NF];
   int         cyc = 0;
   bit         started = 0;

   function automatic int map_idx(int i, int a);
      for (int k = 0; k < rn[i]; k++) if (rmap[i][k] == a) return k;
      return -1;
   endfunction

   function automatic logic [7:0] model_read(int i, int a);
      logic [7:0] d, mask;
      int k;
      if (a >= ms[i]) return 8'h00;
      k = map_idx(i, a);
      if (k >= 0) return sp[i][k];
      d = mm[i][a];
      mask = 8'h00;
      for (int j = 0; j < NF; j++) begin
         if (fen[j] && faddr[j] == a && !mask[fbit[j]]) begin
            d[fbit[j]] = fval[j];
            mask[fbit[j]] = 1'b1;
         end
      end
      return d;
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            left[i] = ms[i] + SP;
            rn[i] = 0; ovf[i] = 0;
            rq[i].delete();
            e_rv[i] = 0; e_rd[i] = 8'h00; e_oor[i] = 0;
            for (int a = 0; a < 256; a++) mm[i][a] = 8'h00;
            for (int k = 0; k < SP; k++) sp[i][k] = 8'h00;
         end else begin
            int a;
            rd_t e;
            a = int'(mem_addr);
            e_oor[i] = 0;
            if (mem_en && left[i] == 0) begin
               if (a >= ms[i]) e_oor[i] = 1;
               if (mem_we) begin
                  if (a < ms[i]) begin
                     if (map_idx(i, a) >= 0) sp[i][map_idx(i, a)] = mem_wdata;
                     else mm[i][a] = mem_wdata;
                  end
               end else begin
                  e.due = cyc + rl[i] - 1;
                  e.d = model_read(i, a);
                  rq[i].push_back(e);
               end
            end
            e_rv[i] = 0;
            if (rq[i].size() > 0 && rq[i][0].due == cyc) begin
               e_rv[i] = 1;
               e_rd[i] = rq[i][0].d;
               void'(rq[i].pop_front());
            end
            if (left[i] > 0) left[i]--;
            if (rep_we && int'(rep_addr) < ms[i] && map_idx(i, int'(rep_addr)) < 0) begin
               if (rn[i] == SP) ovf[i] = 1;
               else begin rmap[i][rn[i]] = int'(rep_addr); rn[i]++; end
            end
         end
      end
      if (rst) begin
         for (int j = 0; j < NF; j++) fen[j] = 0;
         started = 1;
      end else if (flt_we) begin
         fen[flt_idx] = flt_en;
         faddr[flt_idx] = int'(flt_addr);
         fbit[flt_idx] = int'(flt_bit);
         fval[flt_idx] = flt_val;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            chk("m_busy", i, 32'(o_busy[i]), 32'(left[i] > 0));
            chk("m_rvalid", i, 32'(o_rv[i]), 32'(e_rv[i]));
            chk("m_rdata", i, 32'(o_rd[i]), 32'(e_rd[i]));
            chk("m_oor", i, 32'(o_oor[i]), 32'(e_oor[i]));
            chk("m_rep_count", i, 32'(o_rcnt[i]), 32'(rn[i]));
            chk("m_rep_ovf", i, 32'(o_ovf[i]), 32'(ovf[i]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic rd_chk(input logic [7:0] a, input logic [7:0] ea, input logic [7:0] eb);
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = a;
      @(negedge clk);
      mem_en = 1'b0; rep_we = 1'b0;
      chk("rv_lat1", 0, 32'(o_rv[0]), 1);
      chk("rd", 0, 32'(o_rd[0]), 32'(ea));
      chk("rv_early", 1, 32'(o_rv[1]), 0);
      @(negedge clk);
      chk("rv_lat2", 1, 32'(o_rv[1]), 1);
      chk("rd", 1, 32'(o_rd[1]), 32'(eb));
      chk("rv_pulse", 0, 32'(o_rv[0]), 0);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
      @(negedge clk);
      mem_en = 1'b0; mem_we = 1'b0;
   endtask

   task automatic rep(input logic [7:0] a);
      rep_we = 1'b1; rep_addr = a;
      @(negedge clk);
      rep_we = 1'b0;
   endtask

   task automatic flt(input int idx, input bit en, input int a, input int b, input bit v);
      flt_we = 1'b1; flt_idx = 1'(idx); flt_en = en; flt_addr = 8'(a); flt_bit = 3'(b); flt_val = v;
      @(negedge clk);
      flt_we = 1'b0;
   endtask

   initial begin
      int cnt [2];
      int nrv;
      rst = 1'b1; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
      rep_we = 0; rep_addr = 0; flt_we = 0; flt_idx = 0; flt_en = 0;
      flt_addr = 0; flt_bit = 0; flt_val = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      // reset mid-clear restarts the sequence from row 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_rdata", 0, 32'(o_rd[0]), 0);
      chk("rst_rep_count", 0, 32'(o_rcnt[0]), 0);
      cnt[0] = 0; cnt[1] = 0;
      for (int c = 0; c < 300; c++) begin
         if (o_busy[0]) cnt[0]++;
         if (o_busy[1]) cnt[1]++;
         @(negedge clk);
      end
      chk("busy_cycles", 0, cnt[0], 260);
      chk("busy_cycles", 1, cnt[1], 204);

      rd_chk(8'h00, 8'h00, 8'h00);
      rd_chk(8'h11, 8'h00, 8'h00);
      rd_chk(8'hFF, 8'h00, 8'h00);

      wr(8'h10, 8'hA5);
      rd_chk(8'h10, 8'hA5, 8'hA5);
      wr(8'h11, 8'h3C);
      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 8'h10;
      @(negedge clk);
      chk("b2b_rd0", 0, 32'(o_rd[0]), 32'hA5);
      mem_addr = 8'h11;
      @(negedge clk);
      mem_en = 1'b0;
      chk("b2b_rd1", 0, 32'(o_rd[0]), 32'h3C);
      chk("b2b_rv0", 1, 32'(o_rv[1]), 1);
      chk("b2b_rd0", 1, 32'(o_rd[1]), 32'hA5);
      @(negedge clk);
      chk("b2b_rv1", 1, 32'(o_rv[1]), 1);
      chk("b2b_rd1", 1, 32'(o_rd[1]), 32'h3C);

      flt(0, 1, 8'h10, 0, 0);
      flt(1, 1, 8'h10, 0, 1);
      rd_chk(8'h10, 8'hA4, 8'hA4);
      flt(1, 1, 8'h10, 7, 0);
      rd_chk(8'h10, 8'h24, 8'h24);
      rd_chk(8'h11, 8'h3C, 8'h3C);

      // repair in the same cycle as a read: the read still sees the main row
      rep_we = 1'b1; rep_addr = 8'h10;
      rd_chk(8'h10, 8'h24, 8'h24);
      chk("rep_count1", 0, 32'(o_rcnt[0]), 1);
      chk("rep_count1", 1, 32'(o_rcnt[1]), 1);
      rd_chk(8'h10, 8'h00, 8'h00);
      wr(8'h10, 8'hA5);
      rd_chk(8'h10, 8'hA5, 8'hA5);

      rep(8'hF0);
      rep(8'h20);
      rep(8'h30);
      chk("rep_count3", 0, 32'(o_rcnt[0]), 4);
      chk("rep_count3", 1, 32'(o_rcnt[1]), 3);
      rep(8'h40);
      chk("ovf_full", 0, 32'(o_ovf[0]), 1);
      chk("ovf_last", 1, 32'(o_ovf[1]), 0);
      chk("rep_count4", 1, 32'(o_rcnt[1]), 4);
      rep(8'h50);
      chk("ovf_full", 1, 32'(o_ovf[1]), 1);
      rep(8'h20);
      chk("rep_dup", 0, 32'(o_rcnt[0]), 4);
      wr(8'h50, 8'h77);
      rd_chk(8'h50, 8'h77, 8'h77);
      wr(8'h20, 8'h5A);
      rd_chk(8'h20, 8'h5A, 8'h5A);

      wr(8'hF0, 8'h99);
      chk("oor_wr", 1, 32'(o_oor[1]), 1);
      chk("oor_wr", 0, 32'(o_oor[0]), 0);
      @(negedge clk);
      chk("oor_pulse", 1, 32'(o_oor[1]), 0);
      rd_chk(8'hF0, 8'h99, 8'h00);

      mem_en = 1'b1; mem_we = 1'b0; mem_addr = 8'h10;
      @(negedge clk);
      rst = 1'b1; mem_addr = 8'h11;
      @(negedge clk);
      mem_en = 1'b0; rst = 1'b0;
      chk("rst_busy", 1, 32'(o_busy[1]), 1);
      chk("rst_map", 1, 32'(o_rcnt[1]), 0);
      chk("rst_ovf", 1, 32'(o_ovf[1]), 0);
      nrv = 0;
      for (int c = 0; c < 5; c++) begin
         if (o_rv[1]) nrv++;
         @(negedge clk);
      end
      chk("rst_no_rvalid", 1, nrv, 0);
      repeat (300) @(negedge clk);
      rd_chk(8'h10, 8'h00, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
